// File: rtl/imm_control_sequencer.sv
// Hardwired fetch/execute control sequencer for the Mini SRC immediate-class
// instructions: ldi, addi, andi and ori.
// Optional feature: define SINGLE_STEP_EN to add a 'step' input. Each rising
// edge of 'step' then runs exactly one instruction, and 'run' is ignored.
module imm_control_sequencer #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned CNT_W    = 16,
  parameter logic [4:0]  OP_LDI   = 5'b00001,
  parameter logic [4:0]  OP_ADDI  = 5'b01100,
  parameter logic [4:0]  OP_ANDI  = 5'b01101,
  parameter logic [4:0]  OP_ORI   = 5'b01110,
  parameter logic [3:0]  ALU_ADD  = 4'b0011,
  parameter logic [3:0]  ALU_AND  = 4'b0000,
  parameter logic [3:0]  ALU_OR   = 4'b0001,
  parameter logic [4:0]  SEL_PC   = 5'b10100,
  parameter logic [4:0]  SEL_MDR  = 5'b10101,
  parameter logic [4:0]  SEL_ZLO  = 5'b10011,
  parameter logic [4:0]  SEL_R    = 5'b00000
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [4:0]       ir_opcode,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             incPC,
  output logic             e_MAR,
  output logic             ram_read,
  output logic             MDR_read,
  output logic             e_MDR,
  output logic             e_IR,
  output logic             Grb,
  output logic             Gra,
  output logic             e_Rout,
  output logic             e_Rin,
  output logic             BAout,
  output logic             e_Y,
  output logic             imm_sel,
  output logic             e_Z,
  output logic [3:0]       ALU_op,
  output logic [4:0]       BusDataSelect,
  output logic             busy,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned   WaitW    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_WAIT - 1);

  typedef enum logic [2:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StHalt
  } state_e;

  state_e           state_q;
  logic [WaitW-1:0] wait_q;
  logic [4:0]       op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;

  logic op_legal;
  logic wait_last;
  logic start;
  logic cont;

  assign op_legal  = (ir_opcode == OP_LDI)  || (ir_opcode == OP_ADDI) ||
                     (ir_opcode == OP_ANDI) || (ir_opcode == OP_ORI);
  assign wait_last = (wait_q == WaitLast);

`ifdef SINGLE_STEP_EN
  logic step_q;

  // Previous 'step' sample for rising-edge detection.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign start = step & ~step_q;
  assign cont  = 1'b0;
`else
  assign start = run;
  assign cont  = run;
`endif

  // Sequencer state, memory wait counter, latched opcode, sticky illegal flag
  // and retired-instruction counter.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (start) state_q <= StT0;
        StT0:   state_q <= StT1;
        StT1: begin
          if (wait_last) begin
            wait_q  <= '0;
            state_q <= StT2;
          end else begin
            wait_q  <= wait_q + 1'b1;
          end
        end
        StT2:   state_q <= StT3;
        StT3: begin
          if (op_legal) begin
            op_q    <= ir_opcode;
            state_q <= StT4;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= StHalt;
          end
        end
        StT4:   state_q <= StT5;
        StT5: begin
          count_q <= count_q + 1'b1;
          state_q <= cont ? StT0 : StIdle;
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore control decode; T3 gates on the live opcode since IR was just loaded.
  always_comb begin
    incPC         = 1'b0;
    e_MAR         = 1'b0;
    ram_read      = 1'b0;
    MDR_read      = 1'b0;
    e_MDR         = 1'b0;
    e_IR          = 1'b0;
    Grb           = 1'b0;
    Gra           = 1'b0;
    e_Rout        = 1'b0;
    e_Rin         = 1'b0;
    BAout         = 1'b0;
    e_Y           = 1'b0;
    imm_sel       = 1'b0;
    e_Z           = 1'b0;
    ALU_op        = 4'b0000;
    BusDataSelect = SEL_R;
    instr_done    = 1'b0;
    unique case (state_q)
      StT0: begin
        BusDataSelect = SEL_PC;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
      end
      StT1: begin
        ram_read = 1'b1;
        MDR_read = wait_last;
        e_MDR    = wait_last;
      end
      StT2: begin
        BusDataSelect = SEL_MDR;
        e_IR          = 1'b1;
      end
      StT3: begin
        if (op_legal) begin
          Grb    = 1'b1;
          e_Rout = 1'b1;
          e_Y    = 1'b1;
          BAout  = (ir_opcode == OP_LDI); // ldi adds the immediate to zero
        end
      end
      StT4: begin
        imm_sel = 1'b1;
        e_Z     = 1'b1;
        if (op_q == OP_ANDI)     ALU_op = ALU_AND;
        else if (op_q == OP_ORI) ALU_op = ALU_OR;
        else                     ALU_op = ALU_ADD;
      end
      StT5: begin
        BusDataSelect = SEL_ZLO;
        Gra           = 1'b1;
        e_Rin         = 1'b1;
        instr_done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != StIdle) && (state_q != StHalt);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_imm_control_sequencer.sv
// Testbench for imm_control_sequencer: two instances (MEM_WAIT=1/CNT_W=16 and
// MEM_WAIT=3/CNT_W=3) share stimulus and are compared each cycle against a
// cycle-position model of the instruction timeline.
module tb_imm_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic        step;
  logic [4:0]  ir_opcode;

  // {incPC,e_MAR,ram_read,MDR_read,e_MDR,e_IR,Grb,Gra,e_Rout,e_Rin,BAout,e_Y,
  //  imm_sel,e_Z,ALU_op[3:0],BusDataSelect[4:0],busy,instr_done,illegal}
  logic [25:0] obs0, obs1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  always #5 clock = ~clock;

  imm_control_sequencer #(.MEM_WAIT(1), .CNT_W(16)) dut0 (
    .clock(clock), .clear(clear), .run(run), .ir_opcode(ir_opcode),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .incPC(obs0[25]), .e_MAR(obs0[24]), .ram_read(obs0[23]), .MDR_read(obs0[22]),
    .e_MDR(obs0[21]), .e_IR(obs0[20]), .Grb(obs0[19]), .Gra(obs0[18]),
    .e_Rout(obs0[17]), .e_Rin(obs0[16]), .BAout(obs0[15]), .e_Y(obs0[14]),
    .imm_sel(obs0[13]), .e_Z(obs0[12]), .ALU_op(obs0[11:8]),
    .BusDataSelect(obs0[7:3]), .busy(obs0[2]), .instr_done(obs0[1]),
    .illegal(obs0[0]), .instr_count(cnt0)
  );

  imm_control_sequencer #(.MEM_WAIT(3), .CNT_W(3)) dut1 (
    .clock(clock), .clear(clear), .run(run), .ir_opcode(ir_opcode),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .incPC(obs1[25]), .e_MAR(obs1[24]), .ram_read(obs1[23]), .MDR_read(obs1[22]),
    .e_MDR(obs1[21]), .e_IR(obs1[20]), .Grb(obs1[19]), .Gra(obs1[18]),
    .e_Rout(obs1[17]), .e_Rin(obs1[16]), .BAout(obs1[15]), .e_Y(obs1[14]),
    .imm_sel(obs1[13]), .e_Z(obs1[12]), .ALU_op(obs1[11:8]),
    .BusDataSelect(obs1[7:3]), .busy(obs1[2]), .instr_done(obs1[1]),
    .illegal(obs1[0]), .instr_count(cnt1)
  );

  // Model: m_pos = cycle index inside the current instruction (-1 = not running).
  int         m_mw [2] = '{1, 3};
  int         m_cw [2] = '{16, 3};
  int         m_pos [2];
  bit         m_halt [2];
  bit         m_ill [2];
  int         m_cnt [2];
  bit         m_sprev [2];
  logic [4:0] m_op [2];

  function automatic bit legal(input logic [4:0] op);
    return (op == 5'd1) || (op == 5'd12) || (op == 5'd13) || (op == 5'd14);
  endfunction

  function automatic logic [3:0] alu(input logic [4:0] op);
    if (op == 5'd13) return 4'b0000;
    if (op == 5'd14) return 4'b0001;
    return 4'b0011;
  endfunction

  function automatic logic [25:0] exp_vec(input int p, input int m, input logic [4:0] opl,
                                          input logic [4:0] ir, input bit ill);
    logic [25:0] v;
    v = '0;
    if (p == 0) begin
      v[7:3] = 5'b10100; v[24] = 1'b1; v[25] = 1'b1;
    end else if (p >= 1 && p <= m) begin
      v[23] = 1'b1;
      if (p == m) begin v[22] = 1'b1; v[21] = 1'b1; end
    end else if (p == m + 1) begin
      v[7:3] = 5'b10101; v[20] = 1'b1;
    end else if (p == m + 2) begin
      if (legal(ir)) begin
        v[19] = 1'b1; v[17] = 1'b1; v[14] = 1'b1; v[15] = (ir == 5'd1);
      end
    end else if (p == m + 3) begin
      v[13] = 1'b1; v[12] = 1'b1; v[11:8] = alu(opl);
    end else if (p == m + 4) begin
      v[7:3] = 5'b10011; v[18] = 1'b1; v[16] = 1'b1; v[1] = 1'b1;
    end
    v[2] = (p >= 0);
    v[0] = ill;
    return v;
  endfunction

  task automatic model_reset(input int i);
    m_pos[i] = -1; m_halt[i] = 1'b0; m_ill[i] = 1'b0; m_cnt[i] = 0;
    m_sprev[i] = 1'b0; m_op[i] = 5'd0;
  endtask

  task automatic model_adv(input int i);
    bit start, cont;
    int m;
    m = m_mw[i];
`ifdef SINGLE_STEP_EN
    start = step && !m_sprev[i];
    cont  = 1'b0;
`else
    start = run;
    cont  = run;
`endif
    m_sprev[i] = step;
    if (m_halt[i]) begin
      m_pos[i] = -1;
    end else if (m_pos[i] == -1) begin
      if (start) m_pos[i] = 0;
    end else if (m_pos[i] == m + 2) begin
      if (legal(ir_opcode)) begin
        m_op[i] = ir_opcode; m_pos[i]++;
      end else begin
        m_halt[i] = 1'b1; m_ill[i] = 1'b1; m_pos[i] = -1;
      end
    end else if (m_pos[i] == m + 4) begin
      m_cnt[i] = (m_cnt[i] + 1) % (1 << m_cw[i]);
      m_pos[i] = cont ? 0 : -1;
    end else begin
      m_pos[i]++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance model at posedge.
  task automatic cycle(input logic r, input logic c, input logic s, input logic [4:0] op);
    run = r; clear = c; step = s; ir_opcode = op;
    if (!c) begin model_reset(0); model_reset(1); end
    @(negedge clock);
    chk("ctl0", {6'd0, obs0}, {6'd0, exp_vec(m_pos[0], 1, m_op[0], ir_opcode, m_ill[0])});
    chk("cnt0", {16'd0, cnt0}, 32'(m_cnt[0]));
    chk("ctl1", {6'd0, obs1}, {6'd0, exp_vec(m_pos[1], 3, m_op[1], ir_opcode, m_ill[1])});
    chk("cnt1", {29'd0, cnt1}, 32'(m_cnt[1]));
    if (obs0[1]) done_cnt++;
    if (c) begin model_adv(0); model_adv(1); end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [4:0] op;
    model_reset(0); model_reset(1);

    // Reset
    cycle(1'b0, 1'b0, 1'b0, 5'd0);
    cycle(1'b0, 1'b0, 1'b0, 5'd0);
    chk("reset_ctl", {6'd0, obs0}, 32'd0);
    chk("reset_cnt", {16'd0, cnt0}, 32'd0);

    // ldi then andi back to back
    for (int k = 0; k < 13; k++) cycle(1'b1, 1'b1, 1'b0, (k < 7) ? 5'd1 : 5'd13);
`ifndef SINGLE_STEP_EN
    chk("cnt_after_two", {16'd0, cnt0}, 32'd2);
`endif

    // Asynchronous clear while dut0 is in T4
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0, 5'd12);
    cycle(1'b1, 1'b0, 1'b0, 5'd12);
    chk("clear_t4_ctl", {6'd0, obs0}, 32'd0);
    chk("clear_t4_cnt", {16'd0, cnt0}, 32'd0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 1'b0, 5'd14);

    // Illegal opcode halts and holds under run=1
    cycle(1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b1, 1'b0, 5'b11111);
`ifndef SINGLE_STEP_EN
    chk("halt_illegal", {31'd0, obs0[0]}, 32'd1);
    chk("halt_busy", {31'd0, obs0[2]}, 32'd0);
`endif
    cycle(1'b1, 1'b0, 1'b0, 5'd0);
    chk("halt_release", {31'd0, obs0[0]}, 32'd0);

`ifdef SINGLE_STEP_EN
    // Two step pulses run exactly two instructions
    done_cnt = 0;
    for (int n = 0; n < 2; n++) begin
      cycle(1'b1, 1'b1, 1'b1, 5'd1);
      for (int k = 0; k < 9; k++) cycle(1'b1, 1'b1, 1'b0, 5'd1);
    end
    chk("step_done", 32'(done_cnt), 32'd2);
    chk("step_idle", {31'd0, obs0[2]}, 32'd0);
`endif

    // Randomized run/clear/step/opcode traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(99) < 2) op = 5'($urandom_range(31));
      else begin
        case ($urandom_range(3))
          0: op = 5'd1;
          1: op = 5'd12;
          2: op = 5'd13;
          default: op = 5'd14;
        endcase
      end
      cycle(($urandom_range(7) != 0), ($urandom_range(99) != 0),
            ($urandom_range(2) == 0), op);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
